// File: rtl/cfg_byte_to_word.sv
// Reassembles an SPI byte stream (command byte, then LSB-first payload) into
// a command byte plus a configuration word, flagging truncated frames.
module cfg_byte_to_word #(
    parameter int word_width     = 24,
    parameter int timeout_cycles = 1024,
    parameter int bytes_per_word = ((word_width - 1) / 8) + 1,
    parameter int byte_cnt_width = $clog2(bytes_per_word + 1),
    parameter int gap_cnt_width  = $clog2(timeout_cycles + 1)
) (
    input  logic                  i_clk_ILA,
    input  logic                  i_reset,
    input  logic                  i_rx_active,
    input  logic [7:0]            i_slave_byte,
    input  logic                  i_slave_byte_valid,
    output logic [7:0]            o_cmd,
    output logic [word_width-1:0] o_word,
    output logic                  o_word_valid,
    output logic                  o_error,
    output logic                  o_busy
);

    localparam int SHREG_W = bytes_per_word * 8;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    localparam logic [byte_cnt_width-1:0] LAST_BYTE = byte_cnt_width'(bytes_per_word - 1);
    localparam logic [gap_cnt_width-1:0]  GAP_LAST  = gap_cnt_width'(timeout_cycles - 1);

    logic [0:0]                r_state;
    logic [SHREG_W-1:0]        r_shreg;
    logic [7:0]                r_cmd_latch;
    logic [byte_cnt_width-1:0] r_byte_cnt;
    logic [gap_cnt_width-1:0]  r_gap_cnt;
    logic [7:0]                r_cmd;
    logic [word_width-1:0]     r_word;
    logic                      r_word_valid;
    logic                      r_error;

    logic                      w_accept;
    logic                      w_last_byte;
    logic [SHREG_W-1:0]        w_shreg_next;

    assign w_accept    = i_slave_byte_valid & i_rx_active;
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    // New bytes enter at the top so the first payload byte ends up least significant.
    generate
        if (bytes_per_word == 1) begin : g_single_byte
            assign w_shreg_next = i_slave_byte;
        end else begin : g_multi_byte
            assign w_shreg_next = {i_slave_byte, r_shreg[SHREG_W-1:8]};
        end
    endgenerate

    always_ff @(posedge i_clk_ILA) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_cmd_latch  <= '0;
            r_byte_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_cmd        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_error      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd_latch <= i_slave_byte;
                        r_byte_cnt  <= '0;
                        r_gap_cnt   <= '0;
                        r_state     <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    // Chip-select release outranks a byte; a byte outranks the timeout.
                    if (!i_rx_active) begin
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_shreg    <= w_shreg_next;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        r_gap_cnt  <= '0;
                        if (w_last_byte) begin
                            r_word       <= w_shreg_next[word_width-1:0];
                            r_cmd        <= r_cmd_latch;
                            r_word_valid <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end else if (r_gap_cnt == GAP_LAST) begin
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd        = r_cmd;
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_error      = r_error;
    assign o_busy       = (r_state == ST_COLLECT);

endmodule

// File: tb/tb_cfg_byte_to_word.sv
// Directed bench: a 24-bit and a 20-bit instance share one byte stream, so
// both are checked against hand-computed frames, aborts and timeouts.
module tb_cfg_byte_to_word;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_active = 1'b1;
    logic [7:0]  sbyte = 8'h00;
    logic        sbyte_valid = 1'b0;

    logic [7:0]  a_cmd, b_cmd;
    logic [23:0] a_word;
    logic [19:0] b_word;
    logic        a_valid, b_valid, a_err, b_err, a_busy, b_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cfg_byte_to_word #(.word_width(24), .timeout_cycles(16)) dut_a (
        .i_clk_ILA(clk), .i_reset(rst), .i_rx_active(rx_active),
        .i_slave_byte(sbyte), .i_slave_byte_valid(sbyte_valid),
        .o_cmd(a_cmd), .o_word(a_word), .o_word_valid(a_valid),
        .o_error(a_err), .o_busy(a_busy)
    );

    cfg_byte_to_word #(.word_width(20), .timeout_cycles(16)) dut_b (
        .i_clk_ILA(clk), .i_reset(rst), .i_rx_active(rx_active),
        .i_slave_byte(sbyte), .i_slave_byte_valid(sbyte_valid),
        .o_cmd(b_cmd), .o_word(b_word), .o_word_valid(b_valid),
        .o_error(b_err), .o_busy(b_busy)
    );

    // Called at a falling edge; the byte is sampled on the next rising edge
    // and the task returns on the falling edge right after it.
    task automatic send_byte(input logic [7:0] b);
        sbyte       = b;
        sbyte_valid = 1'b1;
        @(negedge clk);
        sbyte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        n_cmp += 6;
        if (a_cmd !== 8'h00) begin n_bad++; $display("FAIL reset_cmd got=%h want=00", a_cmd); end
        if (a_word !== 24'h0) begin n_bad++; $display("FAIL reset_word got=%h want=000000", a_word); end
        if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", a_valid); end
        if (a_err !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%b want=0", a_err); end
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", a_busy); end
        if (b_word !== 20'h0) begin n_bad++; $display("FAIL reset_word_b got=%h want=00000", b_word); end
        rst = 1'b0;
        idle(1);
        $display("reset released");
    endtask

    task automatic test_frame_spaced;
        logic [7:0] bytes [4];
        bytes = '{8'hA5, 8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            if (i < 3) begin
                n_cmp += 2;
                if (a_busy !== 1'b1) begin n_bad++; $display("FAIL spaced_busy byte%0d got=%b want=1", i, a_busy); end
                if (a_valid !== 1'b0) begin n_bad++; $display("FAIL spaced_early_valid byte%0d got=%b want=0", i, a_valid); end
                idle(7);
            end
        end
        n_cmp += 5;
        if (a_valid !== 1'b1) begin n_bad++; $display("FAIL spaced_valid got=%b want=1", a_valid); end
        if (a_cmd !== 8'hA5) begin n_bad++; $display("FAIL spaced_cmd got=%h want=a5", a_cmd); end
        if (a_word !== 24'h332211) begin n_bad++; $display("FAIL spaced_word got=%h want=332211", a_word); end
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL spaced_busy_fall got=%b want=0", a_busy); end
        if (b_word !== 20'h32211) begin n_bad++; $display("FAIL spaced_word_b got=%h want=32211", b_word); end
        $display("frame cmd=%h word=%h", a_cmd, a_word);
        idle(1);
        n_cmp += 1;
        if (a_valid !== 1'b0) begin n_bad++; $display("FAIL spaced_valid_pulse got=%b want=0", a_valid); end
    endtask

    task automatic test_padding_drop;
        send_byte(8'h5A); send_byte(8'h11); send_byte(8'h22); send_byte(8'hF3);
        n_cmp += 4;
        if (b_valid !== 1'b1) begin n_bad++; $display("FAIL pad_valid got=%b want=1", b_valid); end
        if (b_word !== 20'h32211) begin n_bad++; $display("FAIL pad_word got=%h want=32211", b_word); end
        if (b_cmd !== 8'h5A) begin n_bad++; $display("FAIL pad_cmd got=%h want=5a", b_cmd); end
        if (a_word !== 24'hF32211) begin n_bad++; $display("FAIL pad_word_24 got=%h want=f32211", a_word); end
        $display("frame20 cmd=%h word=%h", b_cmd, b_word);
        idle(2);
    endtask

    task automatic test_timeout;
        send_byte(8'hA5); send_byte(8'h11);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            n_cmp += 1;
            if (a_err !== (i == 16)) begin
                n_bad++; $display("FAIL timeout_err edge%0d got=%b want=%b", i, a_err, (i == 16));
            end
        end
        n_cmp += 3;
        if (a_cmd !== 8'h5A) begin n_bad++; $display("FAIL timeout_cmd_hold got=%h want=5a", a_cmd); end
        if (a_word !== 24'hF32211) begin n_bad++; $display("FAIL timeout_word_hold got=%h want=f32211", a_word); end
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy got=%b want=0", a_busy); end
        $display("timeout frame aborted");
        // Same gap, but a byte lands exactly on the threshold edge.
        send_byte(8'hA5); send_byte(8'h11);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            n_cmp += 1;
            if (a_err !== 1'b0) begin n_bad++; $display("FAIL edge_err cycle%0d got=%b want=0", i, a_err); end
        end
        send_byte(8'h22);
        n_cmp += 2;
        if (a_err !== 1'b0) begin n_bad++; $display("FAIL edge_strobe_err got=%b want=0", a_err); end
        if (a_busy !== 1'b1) begin n_bad++; $display("FAIL edge_strobe_busy got=%b want=1", a_busy); end
        send_byte(8'h33);
        n_cmp += 2;
        if (a_valid !== 1'b1) begin n_bad++; $display("FAIL edge_valid got=%b want=1", a_valid); end
        if (a_word !== 24'h332211) begin n_bad++; $display("FAIL edge_word got=%h want=332211", a_word); end
        $display("frame cmd=%h word=%h", a_cmd, a_word);
        idle(2);
    endtask

    task automatic test_abort;
        send_byte(8'hA5); send_byte(8'h11);
        rx_active = 1'b0;
        @(negedge clk);
        n_cmp += 3;
        if (a_err !== 1'b1) begin n_bad++; $display("FAIL abort_err got=%b want=1", a_err); end
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b want=0", a_busy); end
        if (a_word !== 24'h332211) begin n_bad++; $display("FAIL abort_word_hold got=%h want=332211", a_word); end
        rx_active = 1'b1;
        @(negedge clk);
        n_cmp += 1;
        if (a_err !== 1'b0) begin n_bad++; $display("FAIL abort_err_pulse got=%b want=0", a_err); end
        $display("abort frame flagged");
        send_byte(8'hC3); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        n_cmp += 3;
        if (a_valid !== 1'b1) begin n_bad++; $display("FAIL abort_next_valid got=%b want=1", a_valid); end
        if (a_cmd !== 8'hC3) begin n_bad++; $display("FAIL abort_next_cmd got=%h want=c3", a_cmd); end
        if (a_word !== 24'h665544) begin n_bad++; $display("FAIL abort_next_word got=%h want=665544", a_word); end
        $display("frame cmd=%h word=%h", a_cmd, a_word);
        idle(2);
    endtask

    task automatic test_reset_midframe;
        send_byte(8'hA5); send_byte(8'h11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp += 5;
        if (a_cmd !== 8'h00) begin n_bad++; $display("FAIL midrst_cmd got=%h want=00", a_cmd); end
        if (a_word !== 24'h0) begin n_bad++; $display("FAIL midrst_word got=%h want=000000", a_word); end
        if (a_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%b want=0", a_valid); end
        if (a_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err got=%b want=0", a_err); end
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", a_busy); end
        @(negedge clk);
        n_cmp += 1;
        if (a_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err_after got=%b want=0", a_err); end
        $display("reset mid-frame");
        rx_active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h77 + 8'(i));
            n_cmp += 3;
            if (a_busy !== 1'b0) begin n_bad++; $display("FAIL ignored_busy byte%0d got=%b want=0", i, a_busy); end
            if (a_valid !== 1'b0) begin n_bad++; $display("FAIL ignored_valid byte%0d got=%b want=0", i, a_valid); end
            if (a_err !== 1'b0) begin n_bad++; $display("FAIL ignored_err byte%0d got=%b want=0", i, a_err); end
        end
        rx_active = 1'b1;
        idle(2);
        n_cmp += 1;
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL ignored_busy_after got=%b want=0", a_busy); end
        $display("inactive strobes ignored");
    endtask

    task automatic test_back_to_back;
        send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        n_cmp += 4;
        if (a_valid !== 1'b1) begin n_bad++; $display("FAIL b2b1_valid got=%b want=1", a_valid); end
        if (a_cmd !== 8'h01) begin n_bad++; $display("FAIL b2b1_cmd got=%h want=01", a_cmd); end
        if (a_word !== 24'hCCBBAA) begin n_bad++; $display("FAIL b2b1_word got=%h want=ccbbaa", a_word); end
        if (b_word !== 20'hCBBAA) begin n_bad++; $display("FAIL b2b1_word_b got=%h want=cbbaa", b_word); end
        $display("frame cmd=%h word=%h", a_cmd, a_word);
        send_byte(8'h02);
        n_cmp += 2;
        if (a_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_valid got=%b want=0", a_valid); end
        if (a_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got=%b want=1", a_busy); end
        send_byte(8'hDD); send_byte(8'hEE); send_byte(8'hFF);
        n_cmp += 4;
        if (a_valid !== 1'b1) begin n_bad++; $display("FAIL b2b2_valid got=%b want=1", a_valid); end
        if (a_cmd !== 8'h02) begin n_bad++; $display("FAIL b2b2_cmd got=%h want=02", a_cmd); end
        if (a_word !== 24'hFFEEDD) begin n_bad++; $display("FAIL b2b2_word got=%h want=ffeedd", a_word); end
        if (b_word !== 20'hFEEDD) begin n_bad++; $display("FAIL b2b2_word_b got=%h want=feedd", b_word); end
        $display("frame cmd=%h word=%h", a_cmd, a_word);
        idle(2);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_frame_spaced;
        test_padding_drop;
        test_timeout;
        test_abort;
        test_reset_midframe;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
